// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants: ALU op encodings, opcodes, DIV FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        ADDA = 3'b000,
        SUBA = 3'b001,
        MULA = 3'b010,
        DIVA = 3'b011,
        ANDA = 3'b100,
        ORA  = 3'b101,
        XORA = 3'b110,
        NOTA = 3'b111
    } alu_op_e;

    // CPU instruction opcodes decoded upstream into alu_op_e
    localparam logic [4:0] c_OPC_ADD = 5'h00;
    localparam logic [4:0] c_OPC_SUB = 5'h01;
    localparam logic [4:0] c_OPC_MUL = 5'h02;
    localparam logic [4:0] c_OPC_DIV = 5'h03;
    localparam logic [4:0] c_OPC_AND = 5'h04;
    localparam logic [4:0] c_OPC_OR  = 5'h05;
    localparam logic [4:0] c_OPC_XOR = 5'h06;
    localparam logic [4:0] c_OPC_NOT = 5'h07;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit_if
// Description : Issue/result bundle between the execute stage and the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             div_by_zero;

    modport master (
        output flush, in_valid, alu_op, op_a, op_b,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, div_by_zero
    );

    modport slave (
        input  flush, in_valid, alu_op, op_a, op_b,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_div_iter
// Description : Restoring unsigned divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div_iter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             abort,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    input  wire logic             q_neg,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      quotient
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_count;
    logic             r_neg;

    logic [WIDTH-1:0] w_src_rem;
    logic [WIDTH-1:0] w_src_quo;
    logic [WIDTH-1:0] w_src_div;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_nxt_rem;
    logic [WIDTH-1:0] w_nxt_quo;

    // The start edge already performs the first step on the incoming operands
    always_comb begin
        w_src_rem = start ? '0       : r_rem;
        w_src_quo = start ? dividend : r_quo;
        w_src_div = start ? divisor  : r_div;
        w_trial   = {w_src_rem, w_src_quo[WIDTH-1]} - {1'b0, w_src_div};
        if (!w_trial[WIDTH]) begin
            w_nxt_rem = w_trial[WIDTH-1:0];
            w_nxt_quo = {w_src_quo[WIDTH-2:0], 1'b1};
        end else begin
            w_nxt_rem = {w_src_rem[WIDTH-2:0], w_src_quo[WIDTH-1]};
            w_nxt_quo = {w_src_quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_count <= '0;
            r_neg   <= 1'b0;
        end else if (abort) begin
            r_count <= '0;
        end else if (start) begin
            r_rem   <= w_nxt_rem;
            r_quo   <= w_nxt_quo;
            r_div   <= divisor;
            r_neg   <= q_neg;
            r_count <= CW'(WIDTH - 1);
        end else if (r_count != '0) begin
            r_rem   <= w_nxt_rem;
            r_quo   <= w_nxt_quo;
            r_count <= r_count - CW'(1);
        end
    end

    assign busy     = (r_count != '0);
    assign done     = (r_count == CW'(1));
    assign quotient = r_neg ? -r_quo : r_quo;

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with single-cycle ops and an iterative DIV.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_exec_unit_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    div_state_e       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_z, r_n, r_c, r_v;
    logic             r_dbz;
    logic             r_dbz_pend;

    alu_op_e          w_op;
    logic             w_accept;
    logic             w_div_start;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_mul;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic             w_div_busy, w_div_done;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_div_res;

    assign w_op        = alu_op_e'(bus.alu_op);
    assign w_accept    = bus.in_valid && r_in_ready && !bus.flush;
    assign w_div_start = w_accept && (w_op == DIVA) && (bus.op_b != '0);
    assign w_sum       = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    assign w_diff      = {1'b0, bus.op_a} - {1'b0, bus.op_b};
    assign w_mul       = bus.op_a * bus.op_b;
    assign w_abs_a     = bus.op_a[MSB] ? -bus.op_a : bus.op_a;
    assign w_abs_b     = bus.op_b[MSB] ? -bus.op_b : bus.op_b;
    assign w_div_res   = r_dbz_pend ? '1 : w_quot;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_op)
            ADDA: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.op_a[MSB] == bus.op_b[MSB]) && (w_sum[MSB] != bus.op_a[MSB]);
            end
            SUBA: begin
                w_res = w_diff[MSB:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (bus.op_a[MSB] != bus.op_b[MSB]) && (w_diff[MSB] != bus.op_a[MSB]);
            end
            MULA: w_res = w_mul;
            DIVA: w_res = '0;
            ANDA: w_res = bus.op_a & bus.op_b;
            ORA:  w_res = bus.op_a | bus.op_b;
            XORA: w_res = bus.op_a ^ bus.op_b;
            NOTA: w_res = ~bus.op_a;
        endcase
    end

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .abort    (bus.flush),
        .start    (w_div_start),
        .dividend (w_abs_a),
        .divisor  (w_abs_b),
        .q_neg    (bus.op_a[MSB] ^ bus.op_b[MSB]),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_dbz       <= 1'b0;
            r_dbz_pend  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_op == DIVA) begin
                            r_in_ready <= 1'b0;
                            r_dbz_pend <= (bus.op_b == '0);
                            r_state    <= (bus.op_b == '0) ? DIV_FIX : DIV_RUN;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_z         <= (w_res == '0);
                            r_n         <= w_res[MSB];
                            r_c         <= w_c;
                            r_v         <= w_v;
                            r_dbz       <= 1'b0;
                        end
                    end
                end
                DIV_RUN: begin
                    // Idle-divider guard keeps the FSM from wedging if the two ever disagree
                    if (bus.flush || !w_div_busy) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                    end else if (w_div_done) begin
                        r_state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    if (!bus.flush) begin
                        r_out_valid <= 1'b1;
                        r_result    <= w_div_res;
                        r_z         <= (w_div_res == '0);
                        r_n         <= w_div_res[MSB];
                        r_c         <= 1'b0;
                        r_v         <= 1'b0;
                        r_dbz       <= r_dbz_pend;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.result      = r_result;
    assign bus.flag_z      = r_z;
    assign bus.flag_n      = r_n;
    assign bus.flag_c      = r_c;
    assign bus.flag_v      = r_v;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire
